// File: rtl/click_classifier.sv
// Gesture classifier for one debounced button: turns press/click/release
// into single, double, long-press and auto-repeat event pulses.
module click_classifier #(
    parameter int p_long   = 50_000_000,
    parameter int p_gap    = 15_000_000,
    parameter int p_repeat = 10_000_000
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_press,
    input  logic i_click,
    input  logic i_release,
    output logic o_single,
    output logic o_double,
    output logic o_long,
    output logic o_repeat,
    output logic o_busy
);

    localparam int P_MAX_LG = (p_long > p_gap) ? p_long : p_gap;
    localparam int P_MAX    = (P_MAX_LG > p_repeat) ? P_MAX_LG : p_repeat;
    localparam int CW       = $clog2(P_MAX);

    localparam logic [CW-1:0] LONG_LAST   = CW'(p_long - 1);
    localparam logic [CW-1:0] GAP_LAST    = CW'(p_gap - 1);
    localparam logic [CW-1:0] REPEAT_LAST = CW'(p_repeat - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PRESS1,
        S_WAIT2,
        S_PRESS2,
        S_LONG
    } state_t;

    state_t        r_state;
    state_t        w_state_next;
    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_cnt_next;

    logic r_single;
    logic r_double;
    logic r_long;
    logic r_repeat;
    logic r_busy;

    logic w_single_next;
    logic w_double_next;
    logic w_long_next;
    logic w_repeat_next;

    logic w_rel;
    logic w_click;

    // A dropped i_press also counts as release, covering a lost release pulse.
    assign w_rel   = i_release | ~i_press;
    assign w_click = i_click & ~i_release;

    always_comb begin
        w_state_next  = r_state;
        w_cnt_next    = r_cnt;
        w_single_next = 1'b0;
        w_double_next = 1'b0;
        w_long_next   = 1'b0;
        w_repeat_next = 1'b0;

        unique case (r_state)
            S_IDLE: begin
                w_cnt_next = '0;
                if (w_click) begin
                    w_state_next = S_PRESS1;
                end
            end

            S_PRESS1: begin
                if (w_rel) begin
                    w_state_next = S_WAIT2;
                    w_cnt_next   = '0;
                end else if (r_cnt == LONG_LAST) begin
                    w_state_next = S_LONG;
                    w_cnt_next   = '0;
                    w_long_next  = 1'b1;
                end else begin
                    w_cnt_next = r_cnt + 1'b1;
                end
            end

            S_WAIT2: begin
                if (w_click) begin
                    w_state_next = S_PRESS2;
                    w_cnt_next   = '0;
                end else if (r_cnt == GAP_LAST) begin
                    w_state_next  = S_IDLE;
                    w_cnt_next    = '0;
                    w_single_next = 1'b1;
                end else begin
                    w_cnt_next = r_cnt + 1'b1;
                end
            end

            S_PRESS2: begin
                // No timeout here: a held second press never becomes long.
                w_cnt_next = '0;
                if (w_rel) begin
                    w_state_next  = S_IDLE;
                    w_double_next = 1'b1;
                end
            end

            S_LONG: begin
                if (w_rel) begin
                    w_state_next = S_IDLE;
                    w_cnt_next   = '0;
                end else if (r_cnt == REPEAT_LAST) begin
                    w_cnt_next    = '0;
                    w_repeat_next = 1'b1;
                end else begin
                    w_cnt_next = r_cnt + 1'b1;
                end
            end

            default: begin
                w_state_next = S_IDLE;
                w_cnt_next   = '0;
            end
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_single <= 1'b0;
            r_double <= 1'b0;
            r_long   <= 1'b0;
            r_repeat <= 1'b0;
            r_busy   <= 1'b0;
        end else begin
            r_state  <= w_state_next;
            r_cnt    <= w_cnt_next;
            r_single <= w_single_next;
            r_double <= w_double_next;
            r_long   <= w_long_next;
            r_repeat <= w_repeat_next;
            r_busy   <= (w_state_next != S_IDLE);
        end
    end

    assign o_single = r_single;
    assign o_double = r_double;
    assign o_long   = r_long;
    assign o_repeat = r_repeat;
    assign o_busy   = r_busy;

endmodule

// File: tb/tb_click_classifier.sv
// Directed bench for click_classifier with a per-edge expected-output queue.
module tb_click_classifier;

    logic clk;
    logic rst;
    logic press;
    logic click;
    logic release_p;
    logic o_single;
    logic o_double;
    logic o_long;
    logic o_repeat;
    logic o_busy;

    int n_checks;
    int n_pass;

    logic [4:0] exp_q[$];

    click_classifier #(
        .p_long  (8),
        .p_gap   (4),
        .p_repeat(3)
    ) dut (
        .i_clk    (clk),
        .i_rst    (rst),
        .i_press  (press),
        .i_click  (click),
        .i_release(release_p),
        .o_single (o_single),
        .o_double (o_double),
        .o_long   (o_long),
        .o_repeat (o_repeat),
        .o_busy   (o_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Output vector order: {single, double, long, repeat, busy}
    task automatic check(input string name, input int e, input logic [4:0] got, input logic [4:0] want);
        n_checks++;
        assert (got === want) n_pass++;
        else $error("FAIL %s edge %0d: observed %b expected %b (single,double,long,repeat,busy)",
                    name, e, got, want);
    endtask

    task automatic step(input string name, input int e, input logic c, input logic r,
                        input logic p, input logic [4:0] want);
        logic [4:0] popped;
        @(negedge clk);
        click     = c;
        release_p = r;
        press     = p;
        exp_q.push_back(want);
        @(posedge clk);
        #1;
        popped = exp_q.pop_front();
        check(name, e, {o_single, o_double, o_long, o_repeat, o_busy}, popped);
        $display("step %s edge %0d: in c=%b r=%b p=%b out=%b", name, e, c, r, p,
                 {o_single, o_double, o_long, o_repeat, o_busy});
    endtask

    task automatic idle(input string name, input int n);
        for (int i = 0; i < n; i++) begin
            step(name, i, 1'b0, 1'b0, 1'b0, 5'b00000);
        end
    endtask

    // Edges count from the first click (edge 0); -1 means "never".
    task automatic gesture(input string name, input int n, input int c0, input int r0,
                           input int c1, input int r1, input int drop,
                           input int es, input int ed, input int el,
                           input int er0, input int er1, input int bend);
        for (int e = 0; e < n; e++) begin
            logic       cb;
            logic       rb;
            logic       pb;
            logic [4:0] ex;
            int         end0;
            end0 = (r0 >= 0) ? r0 : drop;
            cb = (e == c0) || (e == c1);
            rb = (e == r0) || (e == r1);
            pb = (e >= c0 && e < end0) || (c1 >= 0 && e >= c1 && e < r1);
            ex = {(e == es), (e == ed), (e == el), ((e == er0) || (e == er1)), (e < bend)};
            step(name, e, cb, rb, pb, ex);
        end
    endtask

    initial begin
        n_checks  = 0;
        n_pass    = 0;
        rst       = 1'b1;
        press     = 1'b0;
        click     = 1'b0;
        release_p = 1'b0;

        idle("reset", 2);
        @(negedge clk);
        rst = 1'b0;
        idle("idle", 2);

        // Stray release, then click+release on the same edge: both ignored.
        step("stray_rel", 0, 1'b0, 1'b1, 1'b0, 5'b00000);
        step("click_rel_same", 0, 1'b1, 1'b1, 1'b0, 5'b00000);
        step("click_rel_same", 1, 1'b0, 1'b0, 1'b0, 5'b00000);

        gesture("single", 9, 0, 2, -1, -1, 0, 6, -1, -1, -1, -1, 6);
        idle("gap", 2);
        gesture("double", 9, 0, 2, 4, 6, 0, -1, 6, -1, -1, -1, 6);
        idle("gap", 2);
        gesture("long_repeat", 18, 0, 15, -1, -1, 0, -1, -1, 8, 11, 14, 15);
        idle("gap", 2);
        gesture("rel_at_long", 15, 0, 8, -1, -1, 0, 12, -1, -1, -1, -1, 12);
        idle("gap", 2);
        gesture("click_at_gap", 11, 0, 2, 6, 8, 0, -1, 8, -1, -1, -1, 8);
        idle("gap", 2);
        gesture("lost_release", 10, 0, -1, -1, -1, 3, 7, -1, -1, -1, -1, 7);
        idle("gap", 2);

        // Held into LONG through edge 10, then an asynchronous reset mid-cycle.
        gesture("pre_reset", 11, 0, -1, -1, -1, 1000, -1, -1, 8, -1, -1, 1000);
        #2;
        rst   = 1'b1;
        press = 1'b0;
        #1;
        check("async_reset", 10, {o_single, o_double, o_long, o_repeat, o_busy}, 5'b00000);
        idle("in_reset", 4);
        @(negedge clk);
        rst = 1'b0;
        idle("post_reset", 4);
        gesture("single_after_reset", 9, 0, 2, -1, -1, 0, 6, -1, -1, -1, -1, 6);
        idle("tail", 2);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
